req_unit_fsm: RTL and testbench

- Parametrised successor to the datapath request unit.
- Sits between datapath and cache/memory interface; sequences instruction fetch vs. data access with an explicit FSM.
- Latches data address and store data at issue, gates PC update until the data access completes, supports halt, detects hung data requests via a timeout counter.
- One clock domain; feeds the datapath_cache interface.

---
 rtl/req_unit_fsm_pkg.sv | 14 +
 rtl/req_timeout_ctr.sv | 26 ++
 rtl/req_unit_fsm.sv | 134 +++++++++++++
 tb/tb_req_unit_fsm.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/req_unit_fsm_pkg.sv
// rtl/req_unit_fsm_pkg.sv - shared types for the request unit FSM
package req_unit_fsm_pkg;

    localparam int WORD_W_DEF = 32;

    typedef logic [WORD_W_DEF-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DREQ = 2'd1,
        ST_HALT = 2'd2
    } state_t;

endpackage

// File: rtl/req_timeout_ctr.sv
// rtl/req_timeout_ctr.sv - data-request wait counter with limit detect
module req_timeout_ctr #(
    parameter int TIMEOUT_CYC = 64,
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic clk,
    input  logic resetn,
    input  logic load,
    input  logic en,
    output logic limit_hit
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn || load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // The owner aborts on limit_hit, so cnt never runs past TIMEOUT_CYC-1.
    assign limit_hit = (cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/req_unit_fsm.sv
// rtl/req_unit_fsm.sv - fetch/data request sequencer; REQ_UNIT_PERF_EN adds icount/dstall
module req_unit_fsm
    import req_unit_fsm_pkg::*;
#(
    parameter int WORD_W      = $bits(word_t),
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic              halt,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              imemREN,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              PC_WEN,
    output logic              busy,
    output logic              halted,
`ifdef REQ_UNIT_PERF_EN
    output logic [31:0]       icount,
    output logic [31:0]       dstall,
`endif
    output logic              timeout_err
);

    state_t state_q, state_d;
    logic   issue, finish, set_err;
    logic   ctr_load, ctr_en, limit_hit;

    req_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout_ctr (
        .clk       (CLK),
        .resetn    (nRST),
        .load      (ctr_load),
        .en        (ctr_en),
        .limit_hit (limit_hit)
    );

    always_comb begin
        state_d  = state_q;
        imemREN  = 1'b0;
        busy     = 1'b0;
        halted   = 1'b0;
        PC_WEN   = 1'b0;
        issue    = 1'b0;
        finish   = 1'b0;
        set_err  = 1'b0;
        ctr_load = 1'b0;
        ctr_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                imemREN = 1'b1;
                if (ihit && halt) begin
                    state_d = ST_HALT;
                end else if (ihit && (dREN || dWEN)) begin
                    state_d  = ST_DREQ;
                    issue    = 1'b1;
                    ctr_load = 1'b1;
                end else if (ihit) begin
                    PC_WEN = 1'b1;
                end
            end
            ST_DREQ: begin
                busy = 1'b1;
                if (dhit) begin
                    state_d = ST_IDLE;
                    finish  = 1'b1;
                    PC_WEN  = 1'b1;
                end else if (limit_hit) begin
                    // Abandon the hung access and step past the faulting instruction.
                    state_d = ST_IDLE;
                    finish  = 1'b1;
                    set_err = 1'b1;
                    PC_WEN  = 1'b1;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q     <= ST_IDLE;
            dmemREN     <= 1'b0;
            dmemWEN     <= 1'b0;
            dmemaddr    <= '0;
            dmemstore   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                dmemaddr  <= daddr;
                dmemstore <= dstore;
                dmemWEN   <= dWEN;
                dmemREN   <= dREN && !dWEN;
            end else if (finish) begin
                dmemREN <= 1'b0;
                dmemWEN <= 1'b0;
            end
            if (set_err) begin
                timeout_err <= 1'b1;
            end
        end
    end

`ifdef REQ_UNIT_PERF_EN
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            icount <= '0;
            dstall <= '0;
        end else begin
            if (PC_WEN && (icount != '1)) begin
                icount <= icount + 32'd1;
            end
            if (busy && !dhit && (dstall != '1)) begin
                dstall <= dstall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_req_unit_fsm.sv
// tb/tb_req_unit_fsm.sv - self-checking bench for req_unit_fsm with TIMEOUT_CYC=4
module tb_req_unit_fsm;

    localparam int T = 4;

    logic        CLK = 1'b0;
    logic        nRST, ihit, dhit, dREN, dWEN, halt;
    logic [31:0] daddr, dstore;
    logic        imemREN, dmemREN, dmemWEN, PC_WEN, busy, halted, timeout_err;
    logic [31:0] dmemaddr, dmemstore;
`ifdef REQ_UNIT_PERF_EN
    logic [31:0] icount, dstall;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    req_unit_fsm #(.WORD_W(32), .TIMEOUT_CYC(T)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .dhit        (dhit),
        .dREN        (dREN),
        .dWEN        (dWEN),
        .halt        (halt),
        .daddr       (daddr),
        .dstore      (dstore),
        .imemREN     (imemREN),
        .dmemREN     (dmemREN),
        .dmemWEN     (dmemWEN),
        .dmemaddr    (dmemaddr),
        .dmemstore   (dmemstore),
        .PC_WEN      (PC_WEN),
        .busy        (busy),
        .halted      (halted),
`ifdef REQ_UNIT_PERF_EN
        .icount      (icount),
        .dstall      (dstall),
`endif
        .timeout_err (timeout_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: an outstanding request record plus sticky flags.
    bit          m_valid = 1'b0;
    bit          m_pend, m_wr, m_rd, m_halt, m_err;
    int          m_age;
    logic [31:0] m_addr, m_data;

    always @(posedge CLK) begin
        if (!nRST) begin
            m_valid = 1'b1;
            m_pend = 0; m_wr = 0; m_rd = 0; m_halt = 0; m_err = 0;
            m_age = 0; m_addr = '0; m_data = '0;
        end else if (m_halt) begin
            m_halt = 1'b1;
        end else if (m_pend) begin
            if (dhit) begin
                m_pend = 0;
            end else if (m_age == T) begin
                m_pend = 0;
                m_err  = 1;
            end else begin
                m_age++;
            end
        end else if (ihit && halt) begin
            m_halt = 1'b1;
        end else if (ihit && (dREN || dWEN)) begin
            m_pend = 1; m_age = 1;
            m_addr = daddr; m_data = dstore;
            m_wr = dWEN; m_rd = dREN && !dWEN;
        end
    end

    always @(negedge CLK) begin
        if (m_valid) begin
            logic exp_pc;
            if (m_halt)      exp_pc = 1'b0;
            else if (m_pend) exp_pc = dhit || (m_age == T);
            else             exp_pc = ihit && !halt && !(dREN || dWEN);
            chk("m_imemREN",     32'(imemREN),     32'(!m_pend && !m_halt));
            chk("m_dmemREN",     32'(dmemREN),     32'(m_pend && m_rd));
            chk("m_dmemWEN",     32'(dmemWEN),     32'(m_pend && m_wr));
            chk("m_dmemaddr",    dmemaddr,         m_addr);
            chk("m_dmemstore",   dmemstore,        m_data);
            chk("m_PC_WEN",      32'(PC_WEN),      32'(exp_pc));
            chk("m_busy",        32'(busy),        32'(m_pend));
            chk("m_halted",      32'(halted),      32'(m_halt));
            chk("m_timeout_err", 32'(timeout_err), 32'(m_err));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 0; ihit = 1; dREN = 1; dWEN = 0; halt = 0; dhit = 0;
        daddr = '0; dstore = '0;
        tick();
        @(negedge CLK);
        chk("rst_imemREN", 32'(imemREN), 32'd1);
        chk("rst_dmemREN", 32'(dmemREN), 32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_PC_WEN",  32'(PC_WEN),  32'd0);
        chk("rst_err",     32'(timeout_err), 32'd0);
        tick();
        nRST = 1; ihit = 0; dREN = 0;
        tick();

        // plain fetch, stray dhit ignored
        ihit = 1; dhit = 1;
        @(negedge CLK);
        chk("fetch_PC_WEN", 32'(PC_WEN), 32'd1);
        tick();
        ihit = 0; dhit = 0;

        // load, dhit on third DREQ cycle
        ihit = 1; dREN = 1; daddr = 32'h0000_1000;
        @(negedge CLK);
        chk("ld_issue_PC_WEN", 32'(PC_WEN), 32'd0);
        tick();
        ihit = 0; dREN = 0; daddr = 32'h5555_5555;
        @(negedge CLK);
        chk("ld_dmemREN",  32'(dmemREN), 32'd1);
        chk("ld_dmemaddr", dmemaddr,     32'h0000_1000);
        chk("ld_imemREN",  32'(imemREN), 32'd0);
        chk("ld_PC_WEN",   32'(PC_WEN),  32'd0);
        tick();
        tick();
        dhit = 1;
        @(negedge CLK);
        chk("ld_dhit_PC_WEN", 32'(PC_WEN), 32'd1);
        tick();
        dhit = 0;
        @(negedge CLK);
        chk("ld_done_dmemREN", 32'(dmemREN), 32'd0);
        chk("ld_done_imemREN", 32'(imemREN), 32'd1);

        // store with both dREN and dWEN
        ihit = 1; dREN = 1; dWEN = 1; daddr = 32'h0000_2004; dstore = 32'hDEAD_BEEF;
        tick();
        ihit = 0; dREN = 0; dWEN = 0; dstore = '0; dhit = 1;
        @(negedge CLK);
        chk("st_dmemWEN",   32'(dmemWEN), 32'd1);
        chk("st_dmemREN",   32'(dmemREN), 32'd0);
        chk("st_dmemstore", dmemstore,    32'hDEAD_BEEF);
        chk("st_PC_WEN",    32'(PC_WEN),  32'd1);
        tick();
        dhit = 0;

        // timeout without dhit
        ihit = 1; dREN = 1; daddr = 32'h0000_3000;
        tick();
        ihit = 0; dREN = 0;
        tick(); tick(); tick();
        @(negedge CLK);
        chk("to_abort_PC_WEN", 32'(PC_WEN), 32'd1);
        chk("to_abort_err",    32'(timeout_err), 32'd0);
        tick();
        @(negedge CLK);
        chk("to_err_set", 32'(timeout_err), 32'd1);
        chk("to_imemREN", 32'(imemREN),     32'd1);
        chk("to_dmemREN", 32'(dmemREN),     32'd0);
        tick(); tick();
        @(negedge CLK);
        chk("to_err_sticky", 32'(timeout_err), 32'd1);

        // dhit coinciding with the limit cycle
        nRST = 0;
        tick();
        nRST = 1;
        @(negedge CLK);
        chk("to2_err_clr", 32'(timeout_err), 32'd0);
        ihit = 1; dWEN = 1; daddr = 32'h0000_3004; dstore = 32'h0000_1234;
        tick();
        ihit = 0; dWEN = 0;
        tick(); tick(); tick();
        dhit = 1;
        @(negedge CLK);
        chk("to2_PC_WEN", 32'(PC_WEN), 32'd1);
        tick();
        dhit = 0;
        @(negedge CLK);
        chk("to2_no_err",  32'(timeout_err), 32'd0);
        chk("to2_dmemWEN", 32'(dmemWEN),     32'd0);

        // reset mid-DREQ, then a full-length timeout proves the count restarted
        ihit = 1; dREN = 1; daddr = 32'h0000_4000;
        tick();
        ihit = 0; dREN = 0;
        tick(); tick();
        @(negedge CLK);
        chk("mid_dmemREN", 32'(dmemREN), 32'd1);
        nRST = 0;
        tick();
        nRST = 1;
        @(negedge CLK);
        chk("mid_rst_dmemREN", 32'(dmemREN), 32'd0);
        chk("mid_rst_busy",    32'(busy),    32'd0);
        chk("mid_rst_imemREN", 32'(imemREN), 32'd1);
        ihit = 1; dREN = 1; daddr = 32'h0000_4004;
        tick();
        ihit = 0; dREN = 0;
        tick(); tick();
        @(negedge CLK);
        chk("mid_c3_PC_WEN", 32'(PC_WEN), 32'd0);
        tick();
        @(negedge CLK);
        chk("mid_c4_PC_WEN", 32'(PC_WEN), 32'd1);
        tick();

        // halt beats a decoded store; later hits do nothing
        ihit = 1; halt = 1; dWEN = 1; daddr = 32'h0000_5000;
        @(negedge CLK);
        chk("halt_issue_PC_WEN", 32'(PC_WEN), 32'd0);
        tick();
        halt = 0; dWEN = 0; dREN = 1; dhit = 1;
        @(negedge CLK);
        chk("halt_halted",  32'(halted),  32'd1);
        chk("halt_dmemWEN", 32'(dmemWEN), 32'd0);
        chk("halt_imemREN", 32'(imemREN), 32'd0);
        chk("halt_PC_WEN",  32'(PC_WEN),  32'd0);
        tick(); tick();
        @(negedge CLK);
        chk("halt_stays", 32'(halted), 32'd1);
        chk("halt_busy",  32'(busy),   32'd0);
        ihit = 0; dREN = 0; dhit = 0;
        nRST = 0;
        tick();
        nRST = 1;
        @(negedge CLK);
        chk("halt_rst_halted",  32'(halted),  32'd0);
        chk("halt_rst_imemREN", 32'(imemREN), 32'd1);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
